// File: rtl/gameplay_datapath.sv
// Gameplay datapath: moving block position/direction, saved column,
// score and chances, driven by strobes from the gameplay FSM.
module gameplay_datapath #(
  parameter int unsigned TICK_DIV     = 500000,
  parameter int unsigned STEP         = 1,
  parameter int unsigned X_MAX        = 144,
  parameter int unsigned ROW0_Y       = 104,
  parameter int unsigned INIT_CHANCES = 10,
  parameter int unsigned OVERLAP_TOL  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_x,
  input  logic       ld_y,
  input  logic       ld_d,
  input  logic       enable,
  input  logic       pause,
  input  logic       save_x,
  input  logic       inc_score,
  input  logic       dec_chances,
  input  logic       new_direction,
  input  logic [7:0] new_x_position,
  input  logic [6:0] new_y_position,
  output logic [7:0] x_pos,
  output logic [6:0] y_pos,
  output logic       direction,
  output logic [7:0] prev_x,
  output logic [3:0] score,
  output logic [3:0] chances,
  output logic       c,
  output logic       o
);

  localparam int unsigned   CW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);
  localparam logic [8:0]    STEP9     = 9'(STEP);
  localparam logic [8:0]    XMAX9     = 9'(X_MAX);
  localparam logic [8:0]    TOL9      = 9'(OVERLAP_TOL);
  localparam logic [6:0]    ROW0_Y7   = 7'(ROW0_Y);
  localparam logic [3:0]    INIT_CH4  = 4'(INIT_CHANCES);

  logic [CW-1:0] tick_cnt;
  logic          run;
  logic          tick;
  logic          new_game;
  logic [8:0]    x9;
  logic [8:0]    px9;
  logic [8:0]    x_up;
  logic [8:0]    x_dn;
  logic [8:0]    diff;
  logic [7:0]    x_mv;
  logic          dir_mv;

  assign run      = enable & ~pause & ~ld_x;
  assign tick     = run & (tick_cnt == TICK_LAST);
  assign new_game = ld_y & (new_y_position == ROW0_Y7);
  assign x9       = {1'b0, x_pos};
  assign px9      = {1'b0, prev_x};
  assign x_up     = x9 + STEP9;
  assign x_dn     = x9 - STEP9;

  // Next position/direction if a movement tick occurs, clamping and bouncing at the edges.
  always_comb begin
    x_mv   = x_pos;
    dir_mv = direction;
    if (direction) begin
      if (x_up <= XMAX9) begin
        x_mv = 8'(x_up);
      end else begin
        x_mv   = 8'(XMAX9);
        dir_mv = 1'b0;
      end
    end else begin
      if (x9 >= STEP9) begin
        x_mv = 8'(x_dn);
      end else begin
        x_mv   = '0;
        dir_mv = 1'b1;
      end
    end
  end

  // Movement tick divider: cleared by a position load, frozen by pause or !enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (ld_x || tick) begin
      tick_cnt <= '0;
    end else if (run) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  // Horizontal position and direction; an explicit direction load beats an edge bounce.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_pos     <= '0;
      direction <= 1'b1;
    end else begin
      if (ld_x) begin
        x_pos <= new_x_position;
      end else if (tick) begin
        x_pos <= x_mv;
      end
      if (ld_d) begin
        direction <= new_direction;
      end else if (tick) begin
        direction <= dir_mv;
      end
    end
  end

  // Saved column (takes the pre-edge x even when x is reloaded) and row position.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_x <= '0;
      y_pos  <= ROW0_Y7;
    end else begin
      if (save_x) prev_x <= x_pos;
      if (ld_y)   y_pos  <= new_y_position;
    end
  end

  // Score and chances with saturation; loading the first row restarts the game.
  always_ff @(posedge clk) begin
    if (reset || new_game) begin
      score   <= '0;
      chances <= INIT_CH4;
    end else begin
      if (inc_score && (score != '1))     score   <= score + 4'd1;
      if (dec_chances && (chances != '0)) chances <= chances - 4'd1;
    end
  end

  // Status flags back to the FSM.
  always_comb begin
    diff = (x9 >= px9) ? (x9 - px9) : (px9 - x9);
    o    = (diff <= TOL9);
    c    = (chances != '0);
  end

endmodule

// File: tb/tb_gameplay_datapath.sv
// Bench for gameplay_datapath: directed scenarios plus a randomized strobe
// phase, checked every cycle against a rule-level model, with literal pins.
module tb_gameplay_datapath;

  localparam int TD   = 2;
  localparam int XMAX = 144;
  localparam int ROW0 = 104;
  localparam int INIT = 10;
  localparam int TOL  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ld_x = 1'b0, ld_y = 1'b0, ld_d = 1'b0;
  logic       enable = 1'b0, pause = 1'b0, save_x = 1'b0;
  logic       inc_score = 1'b0, dec_chances = 1'b0, new_direction = 1'b0;
  logic [7:0] new_x_position = '0;
  logic [6:0] new_y_position = '0;
  logic [7:0] x_pos, prev_x;
  logic [6:0] y_pos;
  logic       direction, c, o;
  logic [3:0] score, chances;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  gameplay_datapath #(
    .TICK_DIV(TD), .STEP(1), .X_MAX(XMAX), .ROW0_Y(ROW0),
    .INIT_CHANCES(INIT), .OVERLAP_TOL(TOL)
  ) dut (
    .clk(clk), .reset(reset), .ld_x(ld_x), .ld_y(ld_y), .ld_d(ld_d),
    .enable(enable), .pause(pause), .save_x(save_x), .inc_score(inc_score),
    .dec_chances(dec_chances), .new_direction(new_direction),
    .new_x_position(new_x_position), .new_y_position(new_y_position),
    .x_pos(x_pos), .y_pos(y_pos), .direction(direction), .prev_x(prev_x),
    .score(score), .chances(chances), .c(c), .o(o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state in plain integers, advanced by the rules at each rising edge.
  int m_x = 0, m_y = ROW0, m_dir = 1, m_px = 0, m_sc = 0, m_ch = INIT, m_phase = 0;

  always @(posedge clk) begin
    int ox;
    bit moved;
    if (reset) begin
      m_x = 0; m_y = ROW0; m_dir = 1; m_px = 0; m_sc = 0; m_ch = INIT; m_phase = 0;
    end else begin
      ox = m_x;
      moved = 0;
      if (ld_x) begin
        m_x = new_x_position;
        m_phase = 0;
      end else if (enable && !pause) begin
        m_phase = m_phase + 1;
        if (m_phase == TD) begin
          m_phase = 0;
          moved = 1;
        end
      end
      if (moved) begin
        if (m_dir == 1) begin
          if (ox + 1 <= XMAX) m_x = ox + 1;
          else begin m_x = XMAX; m_dir = 0; end
        end else begin
          if (ox >= 1) m_x = ox - 1;
          else begin m_x = 0; m_dir = 1; end
        end
      end
      if (ld_d) m_dir = new_direction;
      if (save_x) m_px = ox;
      if (ld_y) m_y = new_y_position;
      if (ld_y && new_y_position == ROW0) begin
        m_sc = 0; m_ch = INIT;
      end else begin
        if (inc_score) m_sc = (m_sc < 15) ? m_sc + 1 : 15;
        if (dec_chances) m_ch = (m_ch > 0) ? m_ch - 1 : 0;
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    int d;
    if (chk_en) begin
      d = (m_x > m_px) ? m_x - m_px : m_px - m_x;
      chk("x_pos", x_pos, m_x);
      chk("y_pos", y_pos, m_y);
      chk("direction", direction, m_dir);
      chk("prev_x", prev_x, m_px);
      chk("score", score, m_sc);
      chk("chances", chances, m_ch);
      chk("c", c, (m_ch != 0));
      chk("o", o, (d <= TOL));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_strobes();
    ld_x = 0; ld_y = 0; ld_d = 0; save_x = 0; inc_score = 0; dec_chances = 0;
  endtask

  initial begin
    // reset
    cyc(2);
    reset = 1'b0;
    chk_en = 1'b1;
    chk("rst_x", x_pos, 0);
    chk("rst_y", y_pos, 104);
    chk("rst_dir", direction, 1);
    chk("rst_score", score, 0);
    chk("rst_chances", chances, 10);
    chk("rst_c", c, 1);
    chk("rst_o", o, 1);

    // right bounce
    ld_x = 1; new_x_position = 142; ld_d = 1; new_direction = 1; enable = 1;
    cyc(1); clear_strobes();
    chk("rb_x0", x_pos, 142);
    cyc(2); chk("rb_x1", x_pos, 143);
    cyc(2); chk("rb_x2", x_pos, 144); chk("rb_d2", direction, 1);
    cyc(2); chk("rb_x3", x_pos, 144); chk("rb_d3", direction, 0);
    cyc(2); chk("rb_x4", x_pos, 143);

    // left bounce
    ld_x = 1; new_x_position = 1; ld_d = 1; new_direction = 0;
    cyc(1); clear_strobes();
    chk("lb_x0", x_pos, 1);
    cyc(2); chk("lb_x1", x_pos, 0); chk("lb_d1", direction, 0);
    cyc(2); chk("lb_x2", x_pos, 0); chk("lb_d2", direction, 1);
    cyc(2); chk("lb_x3", x_pos, 1);

    // pause mid-count
    cyc(1);
    pause = 1; cyc(10);
    chk("pause_x", x_pos, 1);
    pause = 0; cyc(1);
    chk("resume_x", x_pos, 2);

    // combined strobe cycle
    enable = 0;
    ld_x = 1; new_x_position = 60;
    cyc(1); clear_strobes();
    save_x = 1; ld_x = 1; new_x_position = 144; inc_score = 1; dec_chances = 1;
    cyc(1); clear_strobes();
    chk("st_px", prev_x, 60);
    chk("st_x", x_pos, 144);
    chk("st_score", score, 1);
    chk("st_ch", chances, 9);
    chk("st_o", o, 0);
    ld_x = 1; new_x_position = 66; cyc(1); chk("o_66", o, 1);
    ld_x = 1; new_x_position = 69; cyc(1); chk("o_69", o, 0);
    ld_x = 1; new_x_position = 52; cyc(1); chk("o_52", o, 1);
    ld_x = 1; new_x_position = 51; cyc(1); chk("o_51", o, 0);
    clear_strobes();

    // chance exhaustion, score saturation, new game
    ld_y = 1; new_y_position = 104; cyc(1); clear_strobes();
    dec_chances = 1; cyc(10);
    chk("ex_ch", chances, 0); chk("ex_c", c, 0);
    cyc(1); chk("ex_ch11", chances, 0);
    dec_chances = 0;
    inc_score = 1; cyc(16); chk("sat_score", score, 15);
    ld_y = 1; new_y_position = 104; dec_chances = 1;
    cyc(1); clear_strobes();
    chk("ng_ch", chances, 10); chk("ng_score", score, 0); chk("ng_c", c, 1);
    inc_score = 1; cyc(1); clear_strobes();
    ld_y = 1; new_y_position = 88; cyc(1); clear_strobes();
    chk("row_y", y_pos, 88); chk("row_score", score, 1); chk("row_ch", chances, 10);

    // randomized strobes, model-checked every cycle
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      ld_x           = ($urandom_range(0, 15) == 0);
      new_x_position = 8'($urandom_range(0, 255));
      ld_y           = ($urandom_range(0, 7) == 0);
      new_y_position = ($urandom_range(0, 1) == 0) ? 7'd104 : 7'($urandom_range(0, 127));
      ld_d           = ($urandom_range(0, 15) == 0);
      new_direction  = 1'($urandom_range(0, 1));
      enable         = ($urandom_range(0, 3) != 0);
      pause          = ($urandom_range(0, 7) == 0);
      save_x         = ($urandom_range(0, 3) == 0);
      inc_score      = ($urandom_range(0, 2) == 0);
      dec_chances    = ($urandom_range(0, 3) == 0);
      cyc(1);
    end
    reset = 0; clear_strobes(); enable = 0;
    cyc(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
